delay_timer_scheduler: RTL and testbench

Round-robin scheduler that shares one delay_timer instance between NUM_REQ requesters. It grants one requester at a time, fires a one-cycle enable pulse into the timer, and waits for the timer's done. It then returns a one-cycle ack to the granted requester. A watchdog aborts a grant whose done never arrives. It sits between the control FSMs that need fixed settle/wait delays and the single shared timer.

---
 rtl/delay_timer_scheduler_if.sv | 34 +++
 rtl/delay_timer_scheduler.sv | 175 +++++++++++++++++
 tb/tb_delay_timer_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/delay_timer_scheduler_if.sv
// Bundle between the requesters, the shared delay_timer and the scheduler.
// The slave modport is the scheduler's view; master is the environment
// (requesters plus the shared timer).
interface delay_timer_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               timer_enable;
  logic               timer_done;
  logic               timeout_err;

  modport slave (
    input  req,
    input  timer_done,
    output ack,
    output grant,
    output busy,
    output timer_enable,
    output timeout_err
  );

  modport master (
    output req,
    output timer_done,
    input  ack,
    input  grant,
    input  busy,
    input  timer_enable,
    input  timeout_err
  );
endinterface

// File: rtl/delay_timer_scheduler.sv
// Round-robin scheduler sharing one delay_timer between NUM_REQ requesters.
// IDLE -> START (one-cycle timer_enable) -> WAIT (done or watchdog) -> ACK.
// Every output is driven straight from a register.
module delay_timer_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  delay_timer_scheduler_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Watchdog holds 0..TIMEOUT_CYCLES; a disabled watchdog still needs one bit.
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [WD_W-1:0]  WD_MAX   = '1;
  localparam logic [PTR_W:0]   NUM_EXT  = (PTR_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [WD_W-1:0]    wd_reg, wd_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic               busy_reg, busy_next;
  logic               timer_enable_reg, timer_enable_next;
  logic               timeout_err_reg, timeout_err_next;

  logic               req_any;
  logic               wd_expired;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic [NUM_REQ-1:0] win_onehot;

  assign req_any = |bus.req;

  // The watchdog fires on the edge that would end the TIMEOUT_CYCLES-th WAIT cycle.
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_reg == WD_LAST);

  // Round-robin search: first asserted request at or above the pointer, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
      if (cand >= NUM_EXT) begin
        cand = cand - NUM_EXT;
      end
      if (!win_found && bus.req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // One-hot form of the winning index, used to load grant.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_win_onehot
      assign win_onehot[gi] = win_found && (win_idx == PTR_W'(gi));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; requests are only looked at in IDLE, done only in WAIT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_any) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (bus.timer_done || wd_expired) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, the rr pointer and the watchdog.
  always_comb begin
    grant_next        = grant_reg;
    busy_next         = busy_reg;
    ack_next          = '0;
    timer_enable_next = 1'b0;
    timeout_err_next  = 1'b0;
    rr_ptr_next       = rr_ptr_reg;
    wd_next           = wd_reg;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          grant_next        = win_onehot;
          busy_next         = 1'b1;
          timer_enable_next = 1'b1;
          rr_ptr_next       = (win_idx == PTR_LAST) ? '0 : (win_idx + 1'b1);
        end
      end
      START: begin
        wd_next = '0;
      end
      WAIT: begin
        // Saturate rather than wrap so a disabled watchdog never aliases.
        if (wd_reg != WD_MAX) begin
          wd_next = wd_reg + 1'b1;
        end
        // A done on the expiry edge wins: the timer did finish.
        if (bus.timer_done) begin
          ack_next = grant_reg;
        end else if (wd_expired) begin
          ack_next         = grant_reg;
          timeout_err_next = 1'b1;
        end
      end
      ACK: begin
        grant_next = '0;
        busy_next  = 1'b0;
      end
      default: begin
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_reg        <= '0;
      ack_reg          <= '0;
      busy_reg         <= 1'b0;
      timer_enable_reg <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      grant_reg        <= grant_next;
      ack_reg          <= ack_next;
      busy_reg         <= busy_next;
      timer_enable_reg <= timer_enable_next;
      timeout_err_reg  <= timeout_err_next;
    end
  end

  // Arbitration pointer and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      wd_reg     <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      wd_reg     <= wd_next;
    end
  end

  assign bus.grant        = grant_reg;
  assign bus.ack          = ack_reg;
  assign bus.busy         = busy_reg;
  assign bus.timer_enable = timer_enable_reg;
  assign bus.timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_delay_timer_scheduler.sv
// Bench for delay_timer_scheduler: directed scenarios followed by random
// transactions, checked against a transaction-level round-robin model.
module tb_delay_timer_scheduler;

  localparam int NR = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   model_rr = 0;

  delay_timer_scheduler_if #(.NUM_REQ(NR)) bus ();

  delay_timer_scheduler #(
    .NUM_REQ       (NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Round-robin pick: first set bit at or after ptr, modulo NR.
  function automatic int rr_pick(input logic [NR-1:0] r, input int ptr);
    int i;
    for (int k = 0; k < NR; k++) begin
      i = (ptr + k) % NR;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".grant"}, 32'(bus.grant), 32'd0);
    check({tag, ".ack"},   32'(bus.ack), 32'd0);
    check({tag, ".busy"},  32'(bus.busy), 32'd0);
    check({tag, ".en"},    32'(bus.timer_enable), 32'd0);
    check({tag, ".err"},   32'(bus.timeout_err), 32'd0);
  endtask

  // One full grant. Called at a negedge with the DUT in IDLE. The timer stub
  // pulses done so that it is sampled in the d-th WAIT cycle (d > TO: never
  // before the watchdog). mid_req replaces req during WAIT; unless hold, the
  // served requester drops its bit after ack.
  task automatic serve(input logic [NR-1:0] pat, input int d, input logic [NR-1:0] mid_req,
                       input bit hold, input string tag);
    int win;
    int ack_k;
    logic [NR-1:0] wmask;
    logic exp_err;
    bus.req = pat;
    win = rr_pick(pat, model_rr);
    model_rr = (win + 1) % NR;
    wmask = NR'(1 << win);
    ack_k = 1 + ((d < TO) ? d : TO);
    exp_err = (d > TO);
    @(posedge clk); @(negedge clk);
    check({tag, ".grant"}, 32'(bus.grant), 32'(wmask));
    check({tag, ".en1"},   32'(bus.timer_enable), 32'd1);
    check({tag, ".busy"},  32'(bus.busy), 32'd1);
    check({tag, ".ack0"},  32'(bus.ack), 32'd0);
    for (int k = 1; k <= ack_k; k++) begin
      bus.timer_done = (k == d + 1);
      if (k == 2) bus.req = mid_req;
      @(posedge clk); @(negedge clk);
      check({tag, ".en0"},   32'(bus.timer_enable), 32'd0);
      check({tag, ".hold"},  32'(bus.grant), 32'(wmask));
      check({tag, ".busyw"}, 32'(bus.busy), 32'd1);
      if (k < ack_k) begin
        check({tag, ".noack"}, 32'(bus.ack), 32'd0);
        check({tag, ".noerr"}, 32'(bus.timeout_err), 32'd0);
      end else begin
        check({tag, ".ack"}, 32'(bus.ack), 32'(wmask));
        check({tag, ".err"}, 32'(bus.timeout_err), 32'(exp_err));
      end
    end
    bus.timer_done = 1'b0;
    if (!hold) bus.req = bus.req & ~wmask;
    @(posedge clk); @(negedge clk);
    check_quiet({tag, ".idle"});
    $display("txn %-10s req=%b win=%0d d=%0d err=%0d", tag, pat, win, d, exp_err);
  endtask

  initial begin
    logic [NR-1:0] pat;
    logic [NR-1:0] mid;
    int d;
    bit hold;

    bus.req = '0;
    bus.timer_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    serve(4'b0010, 3, 4'b0010, 1'b0, "single");
    for (int i = 0; i < 5; i++) serve(4'b1111, 2, 4'b1111, 1'b1, "rr");
    bus.req = '0;
    @(negedge clk);

    serve(4'b1000, 2, 4'b1000, 1'b0, "wrap3");
    serve(4'b0101, 2, 4'b0101, 1'b0, "skip0");
    serve(4'b0100, 2, 4'b0100, 1'b0, "skip2");

    serve(4'b0100, 1000, 4'b0100, 1'b0, "wdog_to");
    serve(4'b0001, TO, 4'b0001, 1'b0, "wdog_edge");

    // Stale done while idle must not produce an ack or start anything.
    bus.timer_done = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.timer_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_quiet("stale");
      @(posedge clk); @(negedge clk);
    end

    serve(4'b0010, 4, 4'b0000, 1'b0, "drop");

    // Reset in WAIT after a grant to req[0] (pointer moves to 1).
    bus.req = 4'b0001;
    model_rr = (rr_pick(4'b0001, model_rr) + 1) % NR;
    @(posedge clk); @(negedge clk);
    check("pre_rst.grant", 32'(bus.grant), 32'b0001);
    @(posedge clk); @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("async_rst");
    bus.req = 4'b1001;
    @(posedge clk); @(negedge clk);
    check_quiet("in_rst");
    rst_n = 1'b1;
    model_rr = 0;
    // From pointer 0, req 1001 must go to req[0], not req[3].
    serve(4'b1001, 3, 4'b1001, 1'b0, "post_rst");
    bus.req = '0;
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      pat  = NR'($urandom_range(1, 15));
      d    = int'($urandom_range(1, 11));
      mid  = NR'($urandom_range(0, 15));
      hold = 1'($urandom_range(0, 1));
      serve(pat, d, mid, hold, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
